// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO master.
// Holds the peripheral register word indices, the FSM state encoding, the
// arbitration grant type and a helper that flags the polling (wait) states.
package uart_pkg;

    // Word indices into the UART peripheral register window.
    localparam int unsigned UART_TX_DATA = 1;
    localparam int unsigned UART_TX_SEND = 2;
    localparam int unsigned UART_TX_FIN  = 3;
    localparam int unsigned UART_RX_DATA = 4;
    localparam int unsigned UART_RX_FLAG = 5;
    localparam int unsigned UART_RX_CLR  = 6;
    localparam int unsigned UART_TX_BUSY = 7;

    typedef enum logic [3:0] {
        StIdle,
        StRxPoll,
        StRxRead,
        StRxClrSet,
        StRxClrWait,
        StRxClrRel,
        StTxLoad,
        StTxStart,
        StTxWaitFin,
        StTxStop,
        StTxWaitIdle
    } state_e;

    // Side that was serviced most recently; used to alternate TX and RX.
    typedef enum logic {
        GrantTx,
        GrantRx
    } grant_e;

    // States that poll a status word and are guarded by the timeout counter.
    function automatic logic is_wait_state(state_e s);
        return (s == StRxClrWait) || (s == StTxWaitFin) || (s == StTxWaitIdle);
    endfunction

endpackage

// File: rtl/uart_mmio_master_if.sv
// Memory-mapped bus between the MMIO master and the UART peripheral.
//   wd      : write data (master -> peripheral)
//   address : word index, 0..7, upper bits zero (master -> peripheral)
//   we      : one-cycle write enable (master -> peripheral)
//   rd      : combinational read data for the current address (peripheral -> master)
interface uart_mmio_master_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] address;
    logic                  we;
    logic [DATA_WIDTH-1:0] rd;

    modport master (
        output wd,
        output address,
        output we,
        input  rd
    );

    modport slave (
        input  wd,
        input  address,
        input  we,
        output rd
    );
endinterface

// File: rtl/uart_poll_timer.sv
// Timeout counter shared by every polling state of the MMIO master.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : clear the count (asserted on entry to a wait state)
//   en         : the FSM is currently in a wait state; count one cycle
//   expired    : the current cycle is the TIMEOUT_CYCLES-th cycle of the wait
module uart_poll_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q is 0 in the first cycle of a wait, so the wait lasts exactly
    // TIMEOUT_CYCLES cycles when it expires.
    assign expired = en && (cnt_q == LastCount);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_mmio_master.sv
// Hardware bus initiator for the UART peripheral register window.
// Moves client TX bytes into the UART and received bytes out of it, without CPU polling.
//   clk, rst_n  : clock and asynchronous active-low reset
//   tx_byte     : byte to transmit, taken when tx_valid && tx_ready
//   tx_valid    : tx_byte is valid
//   tx_ready    : one-entry holding register is empty
//   rx_byte     : last received byte
//   rx_valid    : one-cycle strobe, rx_byte is new
//   timeout_err : sticky, set on any poll timeout, cleared only by reset
//   bus         : wd/address/we outputs (registered) and combinational rd input
module uart_mmio_master
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          tx_byte,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [7:0]          rx_byte,
    output logic                rx_valid,
    output logic                timeout_err,
    uart_mmio_master_if.master  bus
);

    state_e                state_q, state_d;
    grant_e                grant_q, grant_d;
    logic                  hold_full_q, hold_full_d;
    logic [7:0]            hold_q, hold_d;
    logic                  tx_abort_q, tx_abort_d;
    logic [7:0]            rx_byte_q, rx_byte_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] address_q, address_d;
    logic                  we_q, we_d;

    logic timer_load, timer_en, timer_expired;
    logic rd_bit0;
    logic rd_unused;

    assign rd_bit0   = bus.rd[0];
    assign rd_unused = ^bus.rd[DATA_WIDTH-1:8];

    // ------------------------------------------------------------------
    // Poll timeout counter
    // ------------------------------------------------------------------
    assign timer_load = (state_d != state_q) && is_wait_state(state_d);
    assign timer_en   = is_wait_state(state_q);

    uart_poll_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_poll_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        tx_abort_d    = tx_abort_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                // A full hold register goes first only if RX had the last turn,
                // giving strict alternation when both sides are busy.
                if (hold_full_q && (grant_q == GrantRx)) begin
                    state_d = StTxLoad;
                end else begin
                    state_d = StRxPoll;
                end
            end
            StRxPoll: begin
                if (rd_bit0) begin
                    state_d = StRxRead;
                end else begin
                    grant_d = GrantRx;
                    state_d = StIdle;
                end
            end
            StRxRead:   state_d = StRxClrSet;
            StRxClrSet: state_d = StRxClrWait;
            StRxClrWait: begin
                if (!rd_bit0) begin
                    state_d = StRxClrRel;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = StRxClrRel;
                end
            end
            StRxClrRel: begin
                grant_d = GrantRx;
                state_d = StIdle;
            end
            StTxLoad:  state_d = StTxStart;
            StTxStart: state_d = StTxWaitFin;
            StTxWaitFin: begin
                if (rd_bit0) begin
                    state_d = StTxStop;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    tx_abort_d    = 1'b1;
                    state_d       = StTxStop;
                end
            end
            StTxStop: begin
                // After a timeout the byte is dropped: release send and skip the
                // busy wait.
                if (tx_abort_q) begin
                    tx_abort_d = 1'b0;
                    grant_d    = GrantTx;
                    state_d    = StIdle;
                end else begin
                    state_d = StTxWaitIdle;
                end
            end
            StTxWaitIdle: begin
                if (!rd_bit0) begin
                    grant_d = GrantTx;
                    state_d = StIdle;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    tx_abort_d    = 1'b1;
                    state_d       = StTxStop;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs: decoded from the next state and registered, so the
    // address is stable for the whole cycle spent in each state.
    // ------------------------------------------------------------------
    always_comb begin
        address_d = '0;
        wd_d      = '0;
        we_d      = 1'b0;

        unique case (state_d)
            StRxPoll, StRxClrWait: address_d = DATA_WIDTH'(UART_RX_FLAG);
            StRxRead:              address_d = DATA_WIDTH'(UART_RX_DATA);
            StRxClrSet: begin
                we_d      = 1'b1;
                address_d = DATA_WIDTH'(UART_RX_CLR);
                wd_d      = DATA_WIDTH'(1);
            end
            StRxClrRel: begin
                we_d      = 1'b1;
                address_d = DATA_WIDTH'(UART_RX_CLR);
            end
            StTxLoad: begin
                we_d      = 1'b1;
                address_d = DATA_WIDTH'(UART_TX_DATA);
                wd_d      = DATA_WIDTH'(hold_q);
            end
            StTxStart: begin
                we_d      = 1'b1;
                address_d = DATA_WIDTH'(UART_TX_SEND);
                wd_d      = DATA_WIDTH'(1);
            end
            StTxWaitFin: address_d = DATA_WIDTH'(UART_TX_FIN);
            StTxStop: begin
                we_d      = 1'b1;
                address_d = DATA_WIDTH'(UART_TX_SEND);
            end
            StTxWaitIdle: address_d = DATA_WIDTH'(UART_TX_BUSY);
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and RX capture
    // ------------------------------------------------------------------
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        // TX_LOAD is only entered with a full hold, so no accept can collide.
        if (state_q == StTxLoad) begin
            hold_full_d = 1'b0;
        end else if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = tx_byte;
        end
    end

    always_comb begin
        rx_valid_d = (state_q == StRxRead);
        rx_byte_d  = rx_byte_q;
        if (state_q == StRxRead) begin
            rx_byte_d = bus.rd[7:0];
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= GrantTx;
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            tx_abort_q    <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
            address_q     <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            tx_abort_q    <= tx_abort_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
            address_q     <= address_d;
            we_q          <= we_d;
        end
    end

    assign tx_ready    = !hold_full_q;
    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign timeout_err = timeout_err_q;
    assign bus.wd      = wd_q;
    assign bus.address = address_q;
    assign bus.we      = we_q;

endmodule

// File: tb/tb_uart_mmio_master.sv
// Self-checking bench for uart_mmio_master: a behavioural UART register model
// answers the bus, and byte-level scoreboards check what crosses it.
module tb_uart_mmio_master;
    import uart_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       timeout_err;

    always #5 clk = ~clk;

    uart_mmio_master_if #(.DATA_WIDTH(DW)) bus ();

    uart_mmio_master #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // UART peripheral model (status words lag the core by one cycle)
    // ------------------------------------------------------------------
    logic [7:0] p_tx_data, p_rx_data;
    logic       p_busy, p_fin, p_flag, p_clr;
    logic       p_fin_l, p_flag_l, p_busy_l;
    int         p_cnt;
    int         fin_delay = 10;
    bit         fin_disable = 1'b0;
    logic [7:0] sent_q[$];
    logic [7:0] inj_bytes[256];
    int         inj_cnt = 0;
    int         inj_seen = 0;
    int         prst_req = 1;
    int         prst_seen = 0;
    logic [DW-1:0] rd_val;

    always @(posedge clk) begin
        if (prst_req != prst_seen) begin
            prst_seen <= prst_req;
            inj_seen  <= inj_cnt;
            p_tx_data <= '0;
            p_rx_data <= '0;
            p_busy    <= 1'b0;
            p_fin     <= 1'b0;
            p_flag    <= 1'b0;
            p_clr     <= 1'b0;
            p_fin_l   <= 1'b0;
            p_flag_l  <= 1'b0;
            p_busy_l  <= 1'b0;
            p_cnt     <= 0;
        end else begin
            p_fin_l  <= p_fin;
            p_flag_l <= p_flag;
            p_busy_l <= p_busy;
            if (p_busy && !p_fin && !fin_disable) begin
                if (p_cnt >= fin_delay - 1) begin
                    p_fin <= 1'b1;
                    sent_q.push_back(p_tx_data);
                end else begin
                    p_cnt <= p_cnt + 1;
                end
            end
            if (!p_flag && !p_clr && (inj_seen != inj_cnt)) begin
                p_flag    <= 1'b1;
                p_rx_data <= inj_bytes[inj_seen % 256];
                inj_seen  <= inj_seen + 1;
            end
            if (p_clr) p_flag <= 1'b0;
            if (bus.we) begin
                case (bus.address)
                    1: p_tx_data <= bus.wd[7:0];
                    2: begin
                        p_fin <= 1'b0;
                        p_cnt <= 0;
                        p_busy <= bus.wd[0];
                    end
                    6: p_clr <= bus.wd[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address)
            3: rd_val[0]   = p_fin_l;
            4: rd_val[7:0] = p_rx_data;
            5: rd_val[0]   = p_flag_l;
            7: rd_val[0]   = p_busy_l;
            default: ;
        endcase
    end
    assign bus.rd = rd_val;

    // ------------------------------------------------------------------
    // Bus / client monitor
    // ------------------------------------------------------------------
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [7:0]  rx_got[$];
    int          a3_cycles = 0;
    int          we_cnt = 0;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wlog_a.push_back(bus.address);
            wlog_d.push_back(bus.wd);
            we_cnt <= we_cnt + 1;
        end
        if (rx_valid === 1'b1) rx_got.push_back(rx_byte);
        if (bus.address == 3) a3_cycles <= a3_cycles + 1;
    end

    // ------------------------------------------------------------------
    // Reference expectations: every TX byte b appears as (1,b),(2,1),(2,0);
    // every RX byte as one strobe plus (6,1),(6,0); nothing else on the bus.
    // ------------------------------------------------------------------
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] log_tx[$];
    int         n_rx_grp;
    int         log_bad;

    task automatic parse_log(input int base);
        int i;
        i = base;
        log_tx.delete();
        n_rx_grp = 0;
        log_bad  = 0;
        while (i < wlog_a.size()) begin
            if (wlog_a[i] == 1 && i + 2 < wlog_a.size() && wlog_a[i+1] == 2 && wlog_d[i+1] == 1
                && wlog_a[i+2] == 2 && wlog_d[i+2] == 0) begin
                log_tx.push_back(wlog_d[i][7:0]);
                i += 3;
            end else if (wlog_a[i] == 6 && wlog_d[i] == 1 && i + 1 < wlog_a.size()
                         && wlog_a[i+1] == 6 && wlog_d[i+1] == 0) begin
                n_rx_grp++;
                i += 2;
            end else begin
                log_bad++;
                i++;
            end
        end
    endtask

    task automatic check_window(input string tag, input int wbase, input int sbase, input int rbase);
        logic [31:0] v;
        parse_log(wbase);
        check_eq({tag, "_bad_writes"}, log_bad, 0);
        check_eq({tag, "_tx_groups"}, log_tx.size(), exp_tx.size());
        check_eq({tag, "_rx_groups"}, n_rx_grp, exp_rx.size());
        check_eq({tag, "_rx_pulses"}, rx_got.size() - rbase, exp_rx.size());
        for (int k = 0; k < exp_tx.size(); k++) begin
            v = (k < log_tx.size()) ? {24'h0, log_tx[k]} : 32'hxxxxxxxx;
            check_eq({tag, "_wr_byte"}, v, {24'h0, exp_tx[k]});
            v = (sbase + k < sent_q.size()) ? {24'h0, sent_q[sbase+k]} : 32'hxxxxxxxx;
            check_eq({tag, "_sent_byte"}, v, {24'h0, exp_tx[k]});
        end
        for (int k = 0; k < exp_rx.size(); k++) begin
            v = (rbase + k < rx_got.size()) ? {24'h0, rx_got[rbase+k]} : 32'hxxxxxxxx;
            check_eq({tag, "_rx_byte"}, v, {24'h0, exp_rx[k]});
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic push_tx(input logic [7:0] b, input bit keep);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_eq("tx_ready_wait", tx_ready, 1);
        tx_byte  = b;
        tx_valid = 1'b1;
        if (!keep) begin
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic inject_rx(input logic [7:0] b);
        inj_bytes[inj_cnt % 256] = b;
        inj_cnt++;
    endtask

    task automatic wait_drain(input int n_sent, input int n_rx);
        int guard;
        guard = 0;
        while ((sent_q.size() < n_sent || rx_got.size() < n_rx) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            check_eq("drain_sent", sent_q.size(), n_sent);
            check_eq("drain_rx", rx_got.size(), n_rx);
        end
        repeat (60) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wb, sb, rb, a3b, web, guard;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_we", bus.we, 0);
        check_eq("rst_address", bus.address, 0);
        check_eq("rst_wd", bus.wd, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_byte", rx_byte, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single TX
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx = '{8'h41}; exp_rx.delete();
        push_tx(8'h41, 1'b0);
        wait_drain(sb + 1, rb);
        check_window("tx1", wb, sb, rb);

        // Single RX
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx.delete(); exp_rx = '{8'h5A};
        inject_rx(8'h5A);
        wait_drain(sb, rb + 1);
        check_window("rx1", wb, sb, rb);
        check_eq("rx1_rx_byte_held", rx_byte, 8'h5A);

        // Contention
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx = '{8'h33}; exp_rx = '{8'hC3};
        inject_rx(8'hC3);
        push_tx(8'h33, 1'b0);
        wait_drain(sb + 1, rb + 1);
        check_window("cont", wb, sb, rb);

        // Back-to-back with tx_valid held high
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx = '{8'h01, 8'h02, 8'h03, 8'h04}; exp_rx.delete();
        push_tx(8'h01, 1'b1);
        @(negedge clk);
        check_eq("b2b_ready_low", tx_ready, 0);
        push_tx(8'h02, 1'b1);
        push_tx(8'h03, 1'b1);
        push_tx(8'h04, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_drain(sb + 4, rb);
        check_window("b2b", wb, sb, rb);

        // Timeout: finish never rises
        wb = wlog_a.size(); sb = sent_q.size(); a3b = a3_cycles;
        check_eq("to_err_before", timeout_err, 0);
        fin_disable = 1'b1;
        push_tx(8'hAA, 1'b0);
        guard = 0;
        while (!timeout_err && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_eq("to_err_set", timeout_err, 1);
        repeat (60) @(negedge clk);
        check_eq("to_fin_wait_cycles", a3_cycles - a3b, TO);
        check_eq("to_dropped", sent_q.size(), sb);
        parse_log(wb);
        check_eq("to_bad_writes", log_bad, 0);
        check_eq("to_tx_groups", log_tx.size(), 1);
        fin_disable = 1'b0;
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx = '{8'h10}; exp_rx.delete();
        push_tx(8'h10, 1'b0);
        wait_drain(sb + 1, rb);
        check_window("after_to", wb, sb, rb);
        check_eq("to_err_sticky", timeout_err, 1);

        // Randomized mixed traffic
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        fin_delay = $urandom_range(2, 20);
        exp_tx.delete(); exp_rx.delete();
        for (int k = 0; k < 12; k++) exp_tx.push_back(8'($urandom));
        for (int k = 0; k < 8; k++) exp_rx.push_back(8'($urandom));
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    push_tx(exp_tx[k], 1'b0);
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                    inject_rx(exp_rx[j]);
                end
            end
        join
        wait_drain(sb + 12, rb + 8);
        check_window("rand", wb, sb, rb);

        // Reset in the middle of TX_WAIT_FIN
        fin_disable = 1'b1;
        push_tx(8'h77, 1'b0);
        guard = 0;
        while (bus.address != 3 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_eq("mid_reach_fin_wait", bus.address, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", bus.we, 0);
        check_eq("mid_rst_address", bus.address, 0);
        check_eq("mid_rst_wd", bus.wd, 0);
        check_eq("mid_rst_tx_ready", tx_ready, 1);
        check_eq("mid_rst_rx_valid", rx_valid, 0);
        check_eq("mid_rst_rx_byte", rx_byte, 0);
        check_eq("mid_rst_timeout_err", timeout_err, 0);
        web = we_cnt;
        prst_req++;
        fin_disable = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_eq("mid_rst_no_we", we_cnt - web, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wb = wlog_a.size(); sb = sent_q.size(); rb = rx_got.size();
        exp_tx = '{8'h5C}; exp_rx.delete();
        push_tx(8'h5C, 1'b0);
        wait_drain(sb + 1, rb);
        check_window("post_rst", wb, sb, rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
